// File: rtl/dmem_resp.sv
// dmem_resp: single-outstanding data-memory responder with a fixed access latency.
// Define DMEM_MISALIGN_CHK_EN to flag non-word-aligned addresses as access errors.
module dmem_resp #(
  parameter int unsigned LATENCY     = 2,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_addr_i,
  input  logic        req_wen_i,
  input  logic [31:0] req_wdata_i,
  input  logic [3:0]  req_wstrb_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o
);

  // state | meaning
  // IDLE  | ready for a request
  // BUSY  | request latched, latency timer counting down to 0
  // RESP  | response held until the initiator takes it
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam int unsigned AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  state_t        state_q, state_d;
  logic [3:0]    cnt_q;
  logic [31:0]   addr_q;
  logic          wen_q;
  logic [31:0]   wdata_q;
  logic [3:0]    wstrb_q;
  logic [31:0]   rdata_q;
  logic          err_q;
  logic [31:0]   mem [DEPTH_WORDS];

  logic          accept;
  logic          commit;
  logic [31:0]   offset;
  logic [31:0]   off_word;
  logic [AW-1:0] word_idx;
  logic          in_range;
  logic          misalign;
  logic          access_ok;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_valid_i)   state_d = BUSY;
      BUSY:    if (cnt_q == 4'd0) state_d = RESP;
      RESP:    if (resp_ready_i)  state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready_o  = (state_q == IDLE);
    resp_valid_o = (state_q == RESP);
  end

  assign accept = req_valid_i & req_ready_o;
  assign commit = (state_q == BUSY) && (cnt_q == 4'd0);

  always_ff @(posedge clk_i) begin
    if (rst_i)                                cnt_q <= 4'd0;
    else if (accept)                          cnt_q <= CNT_INIT;
    else if (state_q == BUSY && cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      addr_q  <= req_addr_i;
      wen_q   <= req_wen_i;
      wdata_q <= req_wdata_i;
      wstrb_q <= req_wstrb_i;
    end
  end

  // Unsigned wrap makes addresses below BASE_ADDR huge, but the explicit lower bound keeps intent clear.
  assign offset   = addr_q - BASE_ADDR;
  assign off_word = offset >> 2;
  assign in_range = (addr_q >= BASE_ADDR) && (off_word < DEPTH_WORDS);
  assign word_idx = off_word[AW-1:0];

`ifdef DMEM_MISALIGN_CHK_EN
  assign misalign = (addr_q[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  assign access_ok = in_range & ~misalign;

  // Storage is deliberately never reset; a reset on the commit edge cancels the store.
  always_ff @(posedge clk_i) begin
    if (!rst_i && commit && wen_q && access_ok) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb_q[b]) mem[word_idx][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else if (commit) begin
      err_q   <= ~access_ok;
      rdata_q <= (access_ok && !wen_q) ? mem[word_idx] : 32'd0;
    end
  end

  assign resp_rdata_o = rdata_q;
  assign resp_err_o   = err_q;

endmodule

// File: tb/tb_dmem_resp.sv
// Self-checking bench for dmem_resp: directed scenarios followed by randomized
// transactions compared against a byte-level memory model.
module tb_dmem_resp;

  localparam int unsigned LAT   = 2;
  localparam int unsigned DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int unsigned WIN   = 16;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [31:0] req_addr_i;
  logic        req_wen_i;
  logic [31:0] req_wdata_i;
  logic [3:0]  req_wstrb_i;
  logic        resp_valid_o;
  logic        resp_ready_i;
  logic [31:0] resp_rdata_o;
  logic        resp_err_o;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mem_m [WIN];

  dmem_resp #(.LATENCY(LAT), .DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_addr_i   (req_addr_i),
    .req_wen_i    (req_wen_i),
    .req_wdata_i  (req_wdata_i),
    .req_wstrb_i  (req_wstrb_i),
    .resp_valid_o (resp_valid_o),
    .resp_ready_i (resp_ready_i),
    .resp_rdata_o (resp_rdata_o),
    .resp_err_o   (resp_err_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: legal iff BASE <= a < BASE + 4*DEPTH, evaluated in wide integer arithmetic.
  function automatic bit model_ok(input logic [31:0] a);
    longint unsigned la, lo, hi;
    la = longint'(a);
    lo = longint'(BASE);
    hi = lo + 4 * longint'(DEPTH);
    model_ok = (la >= lo) && (la < hi);
`ifdef DMEM_MISALIGN_CHK_EN
    if (a % 4 != 0) model_ok = 1'b0;
`endif
  endfunction

  function automatic int model_idx(input logic [31:0] a);
    model_idx = int'((longint'(a) - longint'(BASE)) / 4);
  endfunction

  task automatic drive_junk();
    req_valid_i  = 1'($urandom_range(0, 1));
    req_addr_i   = $urandom;
    req_wen_i    = 1'($urandom_range(0, 1));
    req_wdata_i  = $urandom;
    req_wstrb_i  = 4'($urandom_range(0, 15));
  endtask

  // Starts and ends at a falling edge with the DUT idle.
  task automatic transact(input logic [31:0] a, input logic w, input logic [31:0] wd,
                          input logic [3:0] ws, input int hold,
                          output logic [31:0] rd, output logic er);
    bit          ok;
    int          idx;
    int          k;
    logic [31:0] exp_rd;
    logic [31:0] t;
    ok     = model_ok(a);
    idx    = ok ? model_idx(a) : 0;
    exp_rd = (ok && !w) ? mem_m[idx] : 32'd0;
    rd     = 32'd0;
    er     = 1'b0;

    chk("ready_idle", {31'd0, req_ready_o}, 32'd1);
    req_valid_i = 1'b1; req_addr_i = a; req_wen_i = w; req_wdata_i = wd; req_wstrb_i = ws;
    resp_ready_i = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    chk("busy_not_ready", {31'd0, req_ready_o}, 32'd0);
    k = 0;
    while (resp_valid_o !== 1'b1 && k < 20) begin
      drive_junk();
      resp_ready_i = 1'($urandom_range(0, 1));
      @(negedge clk_i);
      k++;
    end
    resp_ready_i = 1'b0;
    chk("latency", 32'(k), 32'(LAT));
    if (k >= 20) begin
      req_valid_i = 1'b0;
      return;
    end
    rd = resp_rdata_o;
    er = resp_err_o;
    chk("rdata", resp_rdata_o, exp_rd);
    chk("err", {31'd0, resp_err_o}, {31'd0, ~ok});
    for (int h = 0; h < hold; h++) begin
      drive_junk();
      req_valid_i = 1'b1;
      @(negedge clk_i);
      chk("hold_valid", {31'd0, resp_valid_o}, 32'd1);
      chk("hold_rdata", resp_rdata_o, exp_rd);
      chk("hold_err", {31'd0, resp_err_o}, {31'd0, ~ok});
      chk("hold_not_ready", {31'd0, req_ready_o}, 32'd0);
    end
    req_valid_i  = 1'b0;
    resp_ready_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    resp_ready_i = 1'b0;
    chk("resp_drop", {31'd0, resp_valid_o}, 32'd0);
    if (ok && w) begin
      t = mem_m[idx];
      for (int b = 0; b < 4; b++) if (ws[b]) t[8*b +: 8] = wd[8*b +: 8];
      mem_m[idx] = t;
    end
  endtask

  task automatic rst_in_busy(input logic [31:0] a, input logic [31:0] wd);
    chk("ready_idle", {31'd0, req_ready_o}, 32'd1);
    req_valid_i = 1'b1; req_addr_i = a; req_wen_i = 1'b1; req_wdata_i = wd; req_wstrb_i = 4'hF;
    @(posedge clk_i);
    @(negedge clk_i);
    req_valid_i = 1'b0;
    rst_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_busy_valid", {31'd0, resp_valid_o}, 32'd0);
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("rst_busy_ready", {31'd0, req_ready_o}, 32'd1);
  endtask

  task automatic rst_in_resp(input logic [31:0] a);
    int k;
    req_valid_i = 1'b1; req_addr_i = a; req_wen_i = 1'b0; req_wdata_i = 32'd0; req_wstrb_i = 4'h0;
    resp_ready_i = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    req_valid_i = 1'b0;
    k = 0;
    while (resp_valid_o !== 1'b1 && k < 20) begin
      @(negedge clk_i);
      k++;
    end
    chk("rst_resp_reach", 32'(k), 32'(LAT));
    rst_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_resp_valid", {31'd0, resp_valid_o}, 32'd0);
    chk("rst_resp_rdata", resp_rdata_o, 32'd0);
    chk("rst_resp_err", {31'd0, resp_err_o}, 32'd0);
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("rst_resp_ready", {31'd0, req_ready_o}, 32'd1);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    logic [31:0] oor [5];
    oor[0] = 32'h7FFF_FFFC; oor[1] = 32'h8000_1000; oor[2] = 32'h0000_0000;
    oor[3] = 32'hFFFF_FFFC; oor[4] = 32'h8000_2344;

    rst_i = 1'b1; req_valid_i = 1'b0; req_addr_i = 32'd0; req_wen_i = 1'b0;
    req_wdata_i = 32'd0; req_wstrb_i = 4'h0; resp_ready_i = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("reset_valid", {31'd0, resp_valid_o}, 32'd0);
    chk("reset_rdata", resp_rdata_o, 32'd0);
    chk("reset_err", {31'd0, resp_err_o}, 32'd0);
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("reset_ready", {31'd0, req_ready_o}, 32'd1);

    for (int i = 0; i < int'(WIN); i++)
      transact(BASE + 32'(4 * i), 1'b1, $urandom, 4'hF, 0, rd, er);

    transact(32'h8000_0010, 1'b1, 32'hDEAD_BEEF, 4'hF, 0, rd, er);
    transact(32'h8000_0010, 1'b0, 32'd0, 4'h0, 0, rd, er);
    chk("load_after_store", rd, 32'hDEAD_BEEF);
    transact(32'h8000_0010, 1'b1, 32'h0000_5500, 4'b0010, 1, rd, er);
    transact(32'h8000_0010, 1'b0, 32'd0, 4'h0, 0, rd, er);
    chk("partial_store", rd, 32'hDEAD_55EF);
    transact(32'h8000_0010, 1'b1, 32'hFFFF_FFFF, 4'h0, 0, rd, er);
    chk("wstrb0_err", {31'd0, er}, 32'd0);

    transact(32'h7FFF_FFFC, 1'b0, 32'd0, 4'h0, 0, rd, er);
    chk("below_base_err", {31'd0, er}, 32'd1);
    transact(32'h8000_1000, 1'b1, 32'h5A5A_5A5A, 4'hF, 0, rd, er);
    chk("above_top_err", {31'd0, er}, 32'd1);
    transact(32'h8000_0000, 1'b0, 32'd0, 4'h0, 0, rd, er);

    transact(32'h8000_0010, 1'b0, 32'd0, 4'h0, 5, rd, er);

    rst_in_busy(32'h8000_0020, 32'h1234_5678);
    transact(32'h8000_0020, 1'b0, 32'd0, 4'h0, 0, rd, er);
    rst_in_resp(32'h8000_0024);

    transact(32'h8000_0012, 1'b0, 32'd0, 4'h0, 0, rd, er);
`ifdef DMEM_MISALIGN_CHK_EN
    chk("misalign_err", {31'd0, er}, 32'd1);
`else
    chk("misalign_ignored", rd, 32'hDEAD_55EF);
`endif

    for (int n = 0; n < 150; n++) begin
      logic [31:0] a;
      if ($urandom_range(0, 4) == 0) a = oor[$urandom_range(0, 4)];
      else a = BASE + 32'(4 * $urandom_range(0, WIN - 1)) + 32'($urandom_range(0, 3));
      transact(a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
               int'($urandom_range(0, 3)), rd, er);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_resp.md
DMEM_RESP -- requirements
Module: dmem_resp

Interface
REQ-001 Parameter LATENCY, default 2, cycles from request acceptance to response valid; legal range 1..15.
REQ-002 Parameter DEPTH_WORDS, default 1024, number of 32-bit storage words.
REQ-003 Parameter BASE_ADDR, default 32'h8000_0000, byte address of word 0.
REQ-004 clk_i  input  1  single clock; all state updates on rising edge.
REQ-005 rst_i  input  1  synchronous, active-high reset.
REQ-006 req_valid_i  input  1  initiator presents a request.
REQ-007 req_ready_o  output  1  responder accepts a request this cycle.
REQ-008 req_addr_i  input  32  byte address.
REQ-009 req_wen_i  input  1  1 = store, 0 = load.
REQ-010 req_wdata_i  input  32  store data.
REQ-011 req_wstrb_i  input  4  byte-lane write enables; bit n covers bits 8n+7:8n.
REQ-012 resp_valid_o  output  1  response present.
REQ-013 resp_ready_i  input  1  initiator accepts the response.
REQ-014 resp_rdata_o  output  32  load data; 0 for stores and errors.
REQ-015 resp_err_o  output  1  access error flag, valid with resp_valid_o.

Function
REQ-016 The block SHALL implement FSM states IDLE, BUSY, RESP; one outstanding request maximum.
REQ-017 req_ready_o SHALL be 1 only in IDLE; request handshake = req_valid_i & req_ready_o.
REQ-018 On request handshake the block SHALL latch addr, wen, wdata, wstrb, load the latency counter with LATENCY-1, and move IDLE->BUSY.
REQ-019 In BUSY the counter SHALL decrement each cycle; when it equals 0 the block SHALL perform the access on that edge and move BUSY->RESP.
REQ-020 resp_valid_o SHALL rise exactly LATENCY cycles after the accepting edge (LATENCY=1: valid the cycle after the BUSY cycle).
REQ-021 In RESP, resp_valid_o, resp_rdata_o, resp_err_o SHALL hold stable until resp_valid_o & resp_ready_i, then move RESP->IDLE.
REQ-022 resp_ready_i while not in RESP SHALL be ignored; req_valid_i outside IDLE SHALL be ignored (not queued).
REQ-023 Word index SHALL be (addr - BASE_ADDR) >> 2, computed in 32-bit unsigned arithmetic.
REQ-024 An address below BASE_ADDR or at/above BASE_ADDR + 4*DEPTH_WORDS SHALL give resp_err_o=1, resp_rdata_o=0, no storage change.
REQ-025 Store: only lanes with wstrb bit set SHALL be written; wstrb=0 is a legal no-op with err=0.
REQ-026 Load: resp_rdata_o SHALL be the full addressed word, unshifted; lane extraction and sign extension are the initiator's job.
REQ-027 Storage write SHALL occur only on the BUSY->RESP edge, never at acceptance.
REQ-028 A load immediately following a store to the same word SHALL return the stored data.

Reset
REQ-029 With rst_i=1 at a clock edge the FSM SHALL go to IDLE, counter to 0, resp_valid_o=0, resp_rdata_o=0, resp_err_o=0; req_ready_o=1 the cycle after reset deasserts.
REQ-030 Reset in BUSY SHALL abandon the request; an uncommitted store SHALL NOT modify storage.
REQ-031 Reset in RESP SHALL drop the pending response without handshake.
REQ-032 Storage contents SHALL NOT be reset.

Configuration
REQ-033 Macro DMEM_MISALIGN_CHK_EN defined: addr[1:0] != 0 SHALL give resp_err_o=1, rdata 0, no write.
REQ-034 DMEM_MISALIGN_CHK_EN undefined: addr[1:0] SHALL be ignored; error only per REQ-024.

Verification
REQ-035 LATENCY=2; store 0x8000_0010, data 0xDEADBEEF, wstrb 4'hF; then load same address -> load resp rdata 0xDEADBEEF, err 0, valid 2 cycles after each accept.
REQ-036 Word holds 0xDEADBEEF; store 0x8000_0010, data 0x0000_5500, wstrb 4'b0010; load -> 0xDEAD55EF.
REQ-037 Load 0x7FFF_FFFC and 0x8000_1000 (DEPTH_WORDS=1024) -> err 1, rdata 0; storage unchanged.
REQ-038 Hold resp_ready_i=0 for 5 cycles in RESP with req_valid_i=1 -> outputs stable, req_ready_o=0, no second acceptance; handshake then returns to IDLE.
REQ-039 Store 0x8000_0020 data 0x1234_5678, assert rst_i in BUSY -> resp_valid_o=0 next cycle; subsequent load of that word returns prior contents.
REQ-040 Macro defined: load 0x8000_0012 -> err 1, rdata 0; macro undefined: same load -> word at 0x8000_0010, err 0.
